// File: rtl/store_data_unit.sv
// MEM-stage store path: aligns SB/SH/SW into byte strobes and lane-replicated data,
// runs the SRAM address/data handshake and stalls the pipeline until the write completes.
module store_data_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  st_valid,
    input  logic [7:0]            st_op,
    input  logic [ADDR_W-1:0]     st_addr,
    input  logic [DATA_W-1:0]     st_data,
    input  logic                  flush,
    output logic                  data_req,
    output logic                  data_wr,
    output logic [DATA_W/8-1:0]   data_wstrb,
    output logic [ADDR_W-1:0]     data_addr,
    output logic [DATA_W-1:0]     data_wdata,
    input  logic                  data_addr_ok,
    input  logic                  data_data_ok,
    output logic                  stall,
    output logic                  adel_s,
    output logic [ADDR_W-1:0]     bad_vaddr
);

    // state | meaning
    // IDLE  | no store outstanding; accepts a new store or flags a misaligned one
    // ADDR  | request on the bus, waiting for data_addr_ok (flush may cancel)
    // RESP  | address accepted, waiting for data_data_ok (flush ignored)

    localparam logic [7:0] EXE_SB_OP = 8'b11101000;
    localparam logic [7:0] EXE_SH_OP = 8'b11101001;
    localparam logic [7:0] EXE_SW_OP = 8'b11101011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  adel_q, adel_d;
    logic [ADDR_W-1:0]     bad_vaddr_q, bad_vaddr_d;

    logic                  is_sb, is_sh, is_sw;
    logic                  recognised, misaligned, issue, fault;
    logic [DATA_W/8-1:0]   lane_strb;
    logic [DATA_W-1:0]     lane_data;

    always_comb begin
        is_sb      = (st_op == EXE_SB_OP);
        is_sh      = (st_op == EXE_SH_OP);
        is_sw      = (st_op == EXE_SW_OP);
        recognised = st_valid && (is_sb || is_sh || is_sw) && !flush;
        misaligned = (is_sh && st_addr[0]) || (is_sw && (st_addr[1:0] != 2'b00));
        issue      = (state_q == S_IDLE) && recognised && !misaligned;
        fault      = (state_q == S_IDLE) && recognised && misaligned;
    end

    always_comb begin
        lane_strb = '0;
        lane_data = '0;
        if (is_sb) begin
            lane_strb = 4'b0001 << st_addr[1:0];
            lane_data = {4{st_data[7:0]}};
        end else if (is_sh) begin
            lane_strb = st_addr[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{st_data[15:0]}};
        end else if (is_sw) begin
            lane_strb = 4'b1111;
            lane_data = st_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            wstrb_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            adel_q      <= 1'b0;
            bad_vaddr_q <= '0;
        end else begin
            state_q     <= state_d;
            wstrb_q     <= wstrb_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            adel_q      <= adel_d;
            bad_vaddr_q <= bad_vaddr_d;
        end
    end

    // An accepted address cannot be recalled, so flush only matters while in ADDR.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (issue)             state_d = S_ADDR;
            S_ADDR: if (data_addr_ok)      state_d = S_RESP;
                    else if (flush)        state_d = S_IDLE;
            S_RESP: if (data_data_ok)      state_d = S_IDLE;
            default:                       state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wstrb_d     = wstrb_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        adel_d      = fault;
        bad_vaddr_d = bad_vaddr_q;
        if (issue) begin
            wstrb_d = lane_strb;
            addr_d  = {st_addr[ADDR_W-1:2], 2'b00};
            wdata_d = lane_data;
        end
        if (fault) begin
            bad_vaddr_d = st_addr;
        end
    end

    // stall is released in the data_ok cycle so the pipeline advances on that same edge.
    always_comb begin
        data_req   = (state_q == S_ADDR);
        data_wr    = (state_q == S_ADDR);
        data_wstrb = wstrb_q;
        data_addr  = addr_q;
        data_wdata = wdata_q;
        adel_s     = adel_q;
        bad_vaddr  = bad_vaddr_q;
        stall      = resetn && (issue || (state_q == S_ADDR) ||
                                ((state_q == S_RESP) && !data_data_ok));
    end

endmodule

// File: tb/tb_store_data_unit.sv
// Scoreboard bench for store_data_unit: expected bus transactions and address
// errors are queued when a store is driven and compared when the DUT presents them.
module tb_store_data_unit;

    localparam logic [7:0] EXE_SB_OP = 8'b11101000;
    localparam logic [7:0] EXE_SH_OP = 8'b11101001;
    localparam logic [7:0] EXE_SW_OP = 8'b11101011;
    localparam logic [7:0] EXE_LW_OP = 8'b11100011;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        st_valid;
    logic [7:0]  st_op;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        flush;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic        stall;
    logic        adel_s;
    logic [31:0] bad_vaddr;

    int checks   = 0;
    int failures = 0;

    txn_t        sb_q[$];
    logic [31:0] adel_q[$];

    store_data_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .st_valid     (st_valid),
        .st_op        (st_op),
        .st_addr      (st_addr),
        .st_data      (st_data),
        .flush        (flush),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .stall        (stall),
        .adel_s       (adel_s),
        .bad_vaddr    (bad_vaddr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic is_misaligned(input logic [7:0] op, input logic [31:0] addr);
        case (op)
            EXE_SH_OP: return addr[0];
            EXE_SW_OP: return addr[1:0] != 2'b00;
            default:   return 1'b0;
        endcase
    endfunction

    function automatic txn_t model(input logic [7:0] op, input logic [31:0] addr,
                                   input logic [31:0] data);
        txn_t t;
        t.addr = {addr[31:2], 2'b00};
        case (op)
            EXE_SB_OP: begin
                case (addr[1:0])
                    2'd0: t.strb = 4'b0001;
                    2'd1: t.strb = 4'b0010;
                    2'd2: t.strb = 4'b0100;
                    default: t.strb = 4'b1000;
                endcase
                t.wdata = {data[7:0], data[7:0], data[7:0], data[7:0]};
            end
            EXE_SH_OP: begin
                t.strb  = addr[1] ? 4'b1100 : 4'b0011;
                t.wdata = {data[15:0], data[15:0]};
            end
            default: begin
                t.strb  = 4'b1111;
                t.wdata = data;
            end
        endcase
        return t;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_req"},   {31'd0, data_req}, 32'd0);
        chk({tag, "_wr"},    {31'd0, data_wr}, 32'd0);
        chk({tag, "_wstrb"}, {28'd0, data_wstrb}, 32'd0);
        chk({tag, "_addr"},  data_addr, 32'd0);
        chk({tag, "_wdata"}, data_wdata, 32'd0);
        chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
        chk({tag, "_adel"},  {31'd0, adel_s}, 32'd0);
        chk({tag, "_bad"},   bad_vaddr, 32'd0);
    endtask

    task automatic sb_compare(input string tag);
        txn_t e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_addr"},  data_addr, e.addr);
            chk({tag, "_wstrb"}, {28'd0, data_wstrb}, {28'd0, e.strb});
            chk({tag, "_wdata"}, data_wdata, e.wdata);
            chk({tag, "_wr"},    {31'd0, data_wr}, 32'd1);
        end
    endtask

    // One-cycle store in IDLE; leaves the bench at the following negedge.
    task automatic issue(input string tag, input logic [7:0] op, input logic [31:0] addr,
                         input logic [31:0] data);
        @(negedge clk);
        st_valid = 1'b1; st_op = op; st_addr = addr; st_data = data;
        #1;
        if (is_misaligned(op, addr)) begin
            adel_q.push_back(addr);
            chk({tag, "_stall_mis"}, {31'd0, stall}, 32'd0);
            chk({tag, "_adel_early"}, {31'd0, adel_s}, 32'd0);
        end else begin
            sb_q.push_back(model(op, addr, data));
            chk({tag, "_stall_issue"}, {31'd0, stall}, 32'd1);
        end
        @(negedge clk);
        st_valid = 1'b0;
    endtask

    task automatic complete(input string tag, input int aw, input int dw,
                            input logic flush_aok, input logic flush_resp);
        int req_cycles = 0;
        for (int i = 0; i < aw; i++) begin
            #1;
            req_cycles += int'(data_req);
            chk({tag, "_stall_addr"}, {31'd0, stall}, 32'd1);
            @(negedge clk);
        end
        flush = flush_aok;
        data_addr_ok = 1'b1;
        #1;
        req_cycles += int'(data_req);
        sb_compare(tag);
        @(negedge clk);
        data_addr_ok = 1'b0;
        flush = flush_resp;
        for (int i = 0; i < dw; i++) begin
            #1;
            req_cycles += int'(data_req);
            chk({tag, "_stall_resp"}, {31'd0, stall}, 32'd1);
            @(negedge clk);
        end
        if (dw == 0) begin
            #1;
            chk({tag, "_in_resp"}, {31'd0, stall}, 32'd1);
        end
        flush = 1'b0;
        data_data_ok = 1'b1;
        #1;
        req_cycles += int'(data_req);
        chk({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
        @(negedge clk);
        data_data_ok = 1'b0;
        #1;
        chk({tag, "_idle_req"}, {31'd0, data_req}, 32'd0);
        chk({tag, "_idle_stall"}, {31'd0, stall}, 32'd0);
        chk({tag, "_req_cycles"}, req_cycles, aw + 1);
    endtask

    task automatic fault_check(input string tag);
        logic [31:0] e;
        #1;
        chk({tag, "_adel_pulse"}, {31'd0, adel_s}, 32'd1);
        chk({tag, "_no_req"}, {31'd0, data_req}, 32'd0);
        if (adel_q.size() == 0) begin
            chk({tag, "_adel_q_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = adel_q.pop_front();
            chk({tag, "_bad_vaddr"}, bad_vaddr, e);
        end
        @(negedge clk);
        #1;
        chk({tag, "_adel_drop"}, {31'd0, adel_s}, 32'd0);
        chk({tag, "_no_req2"}, {31'd0, data_req}, 32'd0);
    endtask

    initial begin
        resetn = 1'b0; st_valid = 1'b0; st_op = 8'd0; st_addr = 32'd0; st_data = 32'd0;
        flush = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        resetn = 1'b1;

        issue("sb", EXE_SB_OP, 32'h0000_1003, 32'h0000_00A5);
        complete("sb", 1, 1, 1'b0, 1'b0);

        issue("sh_hi", EXE_SH_OP, 32'h0000_2002, 32'h1234_BEEF);
        complete("sh_hi", 0, 0, 1'b0, 1'b0);
        issue("sh_lo", EXE_SH_OP, 32'h0000_2000, 32'h1234_BEEF);
        complete("sh_lo", 2, 1, 1'b0, 1'b0);
        issue("sb0", EXE_SB_OP, 32'h0000_1001, 32'h0000_003C);
        complete("sb0", 0, 2, 1'b0, 1'b0);

        issue("sw_mis", EXE_SW_OP, 32'h0000_3001, 32'hDEAD_BEEF);
        fault_check("sw_mis");
        issue("sh_mis", EXE_SH_OP, 32'h0000_3003, 32'hDEAD_BEEF);
        fault_check("sh_mis");

        issue("flush_addr", EXE_SW_OP, 32'h0000_4000, 32'hCAFE_F00D);
        flush = 1'b1;
        #1;
        chk("flush_addr_req", {31'd0, data_req}, 32'd1);
        sb_compare("flush_addr");
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_addr_req_drop", {31'd0, data_req}, 32'd0);
        chk("flush_addr_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        #1;
        chk("flush_addr_stay_idle", {31'd0, data_req}, 32'd0);

        issue("flush_resp", EXE_SW_OP, 32'h0000_4100, 32'h0BAD_CAFE);
        complete("flush_resp", 0, 2, 1'b0, 1'b1);
        issue("flush_aok", EXE_SW_OP, 32'h0000_4200, 32'h1357_9BDF);
        complete("flush_aok", 1, 1, 1'b1, 1'b0);

        @(negedge clk);
        st_valid = 1'b1; st_op = EXE_SW_OP; st_addr = 32'h0000_7000; flush = 1'b1;
        #1;
        chk("flush_idle_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        st_addr = 32'h0000_7002;
        #1;
        chk("flush_idle_req", {31'd0, data_req}, 32'd0);
        @(negedge clk);
        st_valid = 1'b0; flush = 1'b0;
        #1;
        chk("flush_idle_adel", {31'd0, adel_s}, 32'd0);
        chk("flush_idle_req2", {31'd0, data_req}, 32'd0);

        data_data_ok = 1'b1;
        @(negedge clk);
        data_data_ok = 1'b0;
        #1;
        chk("stray_dok_req", {31'd0, data_req}, 32'd0);
        chk("stray_dok_stall", {31'd0, stall}, 32'd0);

        issue("rst_resp", EXE_SW_OP, 32'h0000_6000, 32'hA5A5_5A5A);
        data_addr_ok = 1'b1;
        #1;
        sb_compare("rst_resp");
        @(negedge clk);
        data_addr_ok = 1'b0;
        #1;
        chk("rst_resp_in_resp", {31'd0, stall}, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check_all_zero("rst_async");
        @(negedge clk);
        resetn = 1'b1;

        issue("sw_after_rst", EXE_SW_OP, 32'h0000_5000, 32'h8765_4321);
        complete("sw_after_rst", 1, 1, 1'b0, 1'b0);

        @(negedge clk);
        st_valid = 1'b1; st_op = EXE_LW_OP; st_addr = 32'h0000_5004;
        #1;
        chk("lw_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        st_valid = 1'b0;
        #1;
        chk("lw_req", {31'd0, data_req}, 32'd0);
        chk("lw_adel", {31'd0, adel_s}, 32'd0);

        chk("sb_drained", sb_q.size(), 32'd0);
        chk("adel_drained", adel_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
